// File: rtl/roce_stack_rd_req_axi_engine.sv
// RoCE read engine: splits {vaddr,len} commands into 4 KB-safe AXI4 AR bursts and streams R data out as one
// AXI-Stream packet per command; first AR one cycle after ISSUE entry, R->AXIS is 0-latency and stalls R on tready.

module roce_stack_rd_req_axi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Caller never pushes when full nor pops when empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!i_push && i_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_empty    = (r_cnt == '0);
endmodule

module roce_stack_rd_req_axi_engine #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int LEN_WIDTH       = 28,
    parameter int MAX_BURST_BEATS = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    axis_aclk_i,
    input  logic                    areset_i,
    input  logic                    s_req_valid_i,
    output logic                    s_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   s_req_vaddr_i,
    input  logic [LEN_WIDTH-1:0]    s_req_len_i,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr_o,
    output logic [7:0]              m_axi_arlen_o,
    output logic [2:0]              m_axi_arsize_o,
    output logic [1:0]              m_axi_arburst_o,
    output logic                    m_axi_arvalid_o,
    input  logic                    m_axi_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata_i,
    input  logic [1:0]              m_axi_rresp_i,
    input  logic                    m_axi_rlast_i,
    input  logic                    m_axi_rvalid_i,
    output logic                    m_axi_rready_o,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep_o,
    output logic                    m_axis_tlast_o,
    output logic                    m_axis_tvalid_o,
    input  logic                    m_axis_tready_i,
    output logic [1:0]              err_o,
    output logic                    busy_o
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LOG_BYTES = $clog2(BYTES);
    localparam int CW        = $clog2(MAX_OUTSTANDING + 1);
    localparam int EW        = BYTES + 1;
    localparam logic [CW-1:0]        OUT_MAX   = CW'(MAX_OUTSTANDING);
    localparam logic [LEN_WIDTH-1:0] BURST_MAX = LEN_WIDTH'(MAX_BURST_BEATS);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_req_rdy;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_beats_left;
    logic [LEN_WIDTH-1:0]  r_burst;
    logic [BYTES-1:0]      r_last_keep;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [CW-1:0]         r_out_cnt;
    logic [1:0]            r_err;

    logic                  w_req_hs;
    logic                  w_cmd_bad;
    logic [LEN_WIDTH:0]    w_len_rnd;
    logic [LEN_WIDTH-1:0]  w_cmd_beats;
    logic [LOG_BYTES-1:0]  w_len_rem;
    logic [BYTES-1:0]      w_cmd_keep;
    logic [12:0]           w_page_left;
    logic [LEN_WIDTH-1:0]  w_page_beats;
    logic [LEN_WIDTH-1:0]  w_burst;
    logic                  w_ar_hs;
    logic                  w_burst_final;
    logic                  w_fifo_empty;
    logic [EW-1:0]         w_head;
    logic                  w_rready;
    logic                  w_r_hs;
    logic                  w_r_done;
    logic                  w_tlast;

    assign w_req_hs    = s_req_valid_i & r_req_rdy;
    assign w_cmd_bad   = (s_req_len_i == '0) | (s_req_vaddr_i[LOG_BYTES-1:0] != '0);
    assign w_len_rnd   = {1'b0, s_req_len_i} + (LEN_WIDTH + 1)'(BYTES - 1);
    assign w_cmd_beats = LEN_WIDTH'(w_len_rnd >> LOG_BYTES);
    assign w_len_rem   = s_req_len_i[LOG_BYTES-1:0];
    assign w_cmd_keep  = (w_len_rem == '0) ? {BYTES{1'b1}} : ~({BYTES{1'b1}} << w_len_rem);

    // Beats remaining before the next 4 KB page; addr is beat-aligned so the division is exact.
    assign w_page_left  = 13'h1000 - {1'b0, r_addr[11:0]};
    assign w_page_beats = LEN_WIDTH'(w_page_left >> LOG_BYTES);

    always_comb begin
        w_burst = r_beats_left;
        if (BURST_MAX < w_burst) begin
            w_burst = BURST_MAX;
        end
        if (w_page_beats < w_burst) begin
            w_burst = w_page_beats;
        end
    end

    assign w_ar_hs       = r_arvalid & m_axi_arready_i;
    assign w_burst_final = (r_beats_left == r_burst);

    always_ff @(posedge axis_aclk_i or posedge areset_i) begin
        if (areset_i) begin
            r_state      <= S_IDLE;
            r_req_rdy    <= 1'b0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_burst      <= '0;
            r_last_keep  <= '0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_err        <= 2'b00;
        end else begin
            r_err <= {w_r_hs & (m_axi_rresp_i != 2'b00), w_req_hs & w_cmd_bad};
            case (r_state)
                S_IDLE: begin
                    r_req_rdy <= 1'b1;
                    if (w_req_hs && !w_cmd_bad) begin
                        r_req_rdy    <= 1'b0;
                        r_addr       <= s_req_vaddr_i;
                        r_beats_left <= w_cmd_beats;
                        r_last_keep  <= w_cmd_keep;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_arvalid) begin
                        if (m_axi_arready_i) begin
                            r_arvalid    <= 1'b0;
                            r_addr       <= r_addr + (ADDR_WIDTH'(r_burst) << LOG_BYTES);
                            r_beats_left <= r_beats_left - r_burst;
                            if (w_burst_final) begin
                                r_state   <= S_IDLE;
                                r_req_rdy <= 1'b1;
                            end
                        end
                    end else if (r_out_cnt < OUT_MAX) begin
                        // Burst is frozen here so araddr/arlen stay stable until arready.
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_addr;
                        r_arlen   <= 8'(w_burst - LEN_WIDTH'(1));
                        r_burst   <= w_burst;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge axis_aclk_i or posedge areset_i) begin
        if (areset_i) begin
            r_out_cnt <= '0;
        end else if (w_ar_hs && !w_r_done) begin
            r_out_cnt <= r_out_cnt + CW'(1);
        end else if (!w_ar_hs && w_r_done) begin
            r_out_cnt <= r_out_cnt - CW'(1);
        end
    end

    // One entry per in-flight burst: {last burst of its command, that command's final tkeep}.
    roce_stack_rd_req_axi_fifo #(
        .WIDTH (EW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_burst_fifo (
        .i_clk      (axis_aclk_i),
        .i_rst      (areset_i),
        .i_push     (w_ar_hs),
        .i_push_dat ({w_burst_final, r_last_keep}),
        .i_pop      (w_r_done),
        .o_head_dat (w_head),
        .o_empty    (w_fifo_empty)
    );

    assign w_rready = m_axis_tready_i & ~w_fifo_empty;
    assign w_r_hs   = m_axi_rvalid_i & w_rready;
    assign w_r_done = w_r_hs & m_axi_rlast_i;
    assign w_tlast  = m_axi_rlast_i & w_head[BYTES];

    assign s_req_ready_o   = r_req_rdy;
    assign m_axi_araddr_o  = r_araddr;
    assign m_axi_arlen_o   = r_arlen;
    assign m_axi_arsize_o  = 3'(LOG_BYTES);
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arvalid_o = r_arvalid;
    assign m_axi_rready_o  = w_rready;
    assign m_axis_tdata_o  = m_axi_rdata_i;
    assign m_axis_tkeep_o  = w_tlast ? w_head[BYTES-1:0] : {BYTES{1'b1}};
    assign m_axis_tlast_o  = w_tlast;
    assign m_axis_tvalid_o = m_axi_rvalid_i & ~w_fifo_empty;
    assign err_o           = r_err;
    assign busy_o          = (r_state != S_IDLE) | (r_out_cnt != '0);
endmodule

// File: tb/tb_roce_stack_rd_req_axi_engine.sv
// Bench for roce_stack_rd_req_axi_engine: random-ready AXI slave and AXIS sink, expected bursts and
// packets derived per beat from the command's byte range.
`timescale 1ns/1ps
module tb_roce_stack_rd_req_axi_engine;
    localparam int DW  = 512;
    localparam int NB  = 64;
    localparam int MBB = 64;

    typedef struct packed { logic [63:0] addr; logic [7:0] len; } ar_t;
    typedef struct packed { logic [DW-1:0] data; logic [NB-1:0] keep; logic last; } beat_t;
    typedef struct packed { logic [63:0] addr; logic last; } rbeat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_valid, req_ready;
    logic [63:0] req_vaddr;
    logic [27:0] req_len;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [DW-1:0] tdata;
    logic [NB-1:0] tkeep;
    logic        tlast, tvalid, tready;
    logic [1:0]  err;
    logic        busy;

    always #5 clk = ~clk;

    roce_stack_rd_req_axi_engine dut (
        .axis_aclk_i(clk), .areset_i(rst),
        .s_req_valid_i(req_valid), .s_req_ready_o(req_ready),
        .s_req_vaddr_i(req_vaddr), .s_req_len_i(req_len),
        .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
        .m_axi_arburst_o(arburst), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
        .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
        .m_axis_tdata_o(tdata), .m_axis_tkeep_o(tkeep), .m_axis_tlast_o(tlast),
        .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
        .err_o(err), .busy_o(busy)
    );

    int total = 0;
    int bad = 0;
    ar_t    exp_ar[$];
    ar_t    obs_ar[$];
    int     obs_ar_rl[$];
    beat_t  exp_bt[$];
    beat_t  obs_bt[$];
    logic [1:0] obs_err[$];
    rbeat_t slv_q[$];
    logic   r_hold = 1'b0;
    logic [63:0] inj_addr = '1;
    logic [63:0] salt = '0;
    int rl_cnt = 0;
    int ar_cnt = 0;
    int max_out = 0;
    int stable_viol = 0;

    function automatic logic [DW-1:0] mem_data(input logic [63:0] a);
        return {8{a ^ salt}};
    endfunction

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Walk the command beat by beat; a new burst starts at a 4 KB page or after MBB beats.
    task automatic model_cmd(input logic [63:0] va, input int ln);
        int nbeat;
        int cur;
        int rem;
        logic [63:0] a;
        logic [63:0] start;
        logic [NB-1:0] lk;
        ar_t ar;
        beat_t b;
        nbeat = (ln + NB - 1) / NB;
        rem = ln % NB;
        lk = '1;
        if (rem != 0) lk = (64'd1 << rem) - 64'd1;
        cur = 0;
        start = va;
        for (int i = 0; i < nbeat; i++) begin
            a = va + 64'(i) * 64'(NB);
            if (i != 0 && (a[11:0] == 12'h000 || cur == MBB)) begin
                ar.addr = start;
                ar.len = 8'(cur - 1);
                exp_ar.push_back(ar);
                start = a;
                cur = 0;
            end
            cur++;
            b.data = mem_data(a);
            b.keep = (i == nbeat - 1) ? lk : {NB{1'b1}};
            b.last = (i == nbeat - 1);
            exp_bt.push_back(b);
        end
        ar.addr = start;
        ar.len = 8'(cur - 1);
        exp_ar.push_back(ar);
    endtask

    task automatic send_cmd(input logic [63:0] va, input logic [27:0] ln);
        logic done;
        done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = va;
        req_len = ln;
        for (int i = 0; i < 5000 && !done; i++) begin
            #1;
            if (req_ready) done = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk64("cmd_accept", 64'(done), 64'd1);
    endtask

    task automatic run_cmd(input logic [63:0] va, input int ln);
        model_cmd(va, ln);
        send_cmd(va, 28'(ln));
        chk64("busy_after_accept", 64'(busy), 64'd1);
        chk64("ready_after_accept", 64'(req_ready), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 6000 && (busy || slv_q.size() != 0 || rvalid)) begin
            @(negedge clk);
            #3;
            n++;
        end
        total++;
        assert (n < 6000) else begin
            bad++;
            $error("FAIL %s_timeout: observed=%0d cycles expected=below 6000", tag, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_err(input string tag, input int n, input logic [1:0] v);
        chk64({tag, "_err_pulses"}, 64'(obs_err.size()), 64'(n));
        for (int i = 0; i < obs_err.size(); i++) chk64({tag, "_err_code"}, 64'(obs_err[i]), 64'(v));
        obs_err.delete();
    endtask

    task automatic check_all(input string tag);
        chk64({tag, "_ar_count"}, 64'(obs_ar.size()), 64'(exp_ar.size()));
        for (int i = 0; i < exp_ar.size() && i < obs_ar.size(); i++) begin
            chk64({tag, "_araddr"}, obs_ar[i].addr, exp_ar[i].addr);
            chk64({tag, "_arlen"}, 64'(obs_ar[i].len), 64'(exp_ar[i].len));
        end
        chk64({tag, "_beat_count"}, 64'(obs_bt.size()), 64'(exp_bt.size()));
        for (int i = 0; i < exp_bt.size() && i < obs_bt.size(); i++) begin
            chkd({tag, "_tdata"}, obs_bt[i].data, exp_bt[i].data);
            chk64({tag, "_tkeep"}, obs_bt[i].keep, exp_bt[i].keep);
            chk64({tag, "_tlast"}, 64'(obs_bt[i].last), 64'(exp_bt[i].last));
        end
        exp_ar.delete();
        obs_ar.delete();
        obs_ar_rl.delete();
        exp_bt.delete();
        obs_bt.delete();
    endtask

    initial begin : ar_slave
        logic pend;
        logic [63:0] pa;
        logic [7:0] pl;
        ar_t ar;
        rbeat_t rb;
        pend = 1'b0;
        pa = '0;
        pl = '0;
        arready = 1'b0;
        forever begin
            @(negedge clk);
            arready = ($urandom_range(0, 3) != 0);
            #2;
            if (pend && !(arvalid && araddr == pa && arlen == pl)) stable_viol++;
            pend = 1'b0;
            if (arvalid) begin
                if (arready) begin
                    ar.addr = araddr;
                    ar.len = arlen;
                    obs_ar.push_back(ar);
                    obs_ar_rl.push_back(rl_cnt);
                    ar_cnt++;
                    if (ar_cnt - rl_cnt > max_out) max_out = ar_cnt - rl_cnt;
                    for (int i = 0; i <= int'(arlen); i++) begin
                        rb.addr = araddr + 64'(i) * 64'(NB);
                        rb.last = (i == int'(arlen));
                        slv_q.push_back(rb);
                    end
                end else begin
                    pend = 1'b1;
                    pa = araddr;
                    pl = arlen;
                end
            end
        end
    end

    initial begin : r_slave
        logic acc;
        acc = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        rdata = '0;
        rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (acc) begin
                rvalid = 1'b0;
                acc = 1'b0;
                void'(slv_q.pop_front());
            end
            if (!rvalid && slv_q.size() > 0 && !r_hold && $urandom_range(0, 3) != 0) begin
                rvalid = 1'b1;
                rdata = mem_data(slv_q[0].addr);
                rlast = slv_q[0].last;
                rresp = (slv_q[0].addr == inj_addr) ? 2'b10 : 2'b00;
            end
            #2;
            if (rvalid && rready) begin
                acc = 1'b1;
                if (rlast) rl_cnt++;
            end
        end
    end

    initial begin : axis_sink
        beat_t b;
        tready = 1'b0;
        forever begin
            @(negedge clk);
            tready = ($urandom_range(0, 3) != 0);
            #2;
            if (tvalid && tready) begin
                b.data = tdata;
                b.keep = tkeep;
                b.last = tlast;
                obs_bt.push_back(b);
            end
            if (err != 2'b00) obs_err.push_back(err);
        end
    end

    initial begin : main
        logic [63:0] va;
        int ln;
        int rl_base;
        salt = {$urandom, $urandom};
        req_valid = 1'b0;
        req_vaddr = '0;
        req_len = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk64("rst_req_ready", 64'(req_ready), 64'd0);
        chk64("rst_arvalid", 64'(arvalid), 64'd0);
        chk64("rst_araddr", araddr, 64'd0);
        chk64("rst_arlen", 64'(arlen), 64'd0);
        chk64("rst_tvalid", 64'(tvalid), 64'd0);
        chk64("rst_rready", 64'(rready), 64'd0);
        chk64("rst_err", 64'(err), 64'd0);
        chk64("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk64("idle_req_ready", 64'(req_ready), 64'd1);
        chk64("arsize", 64'(arsize), 64'd6);
        chk64("arburst", 64'(arburst), 64'd1);

        run_cmd(64'h1000, 256);
        wait_idle("c1000");
        chk_err("c1000", 0, 2'b00);
        check_all("c1000");

        run_cmd(64'h1F80, 256);
        wait_idle("c1f80");
        chk_err("c1f80", 0, 2'b00);
        check_all("c1f80");

        run_cmd(64'h0, 100);
        wait_idle("len100");
        chk64("len100_last_keep", (obs_bt.size() == 2) ? obs_bt[1].keep : 64'd0, 64'h0000_000F_FFFF_FFFF);
        chk_err("len100", 0, 2'b00);
        check_all("len100");

        run_cmd(64'h0, 8192);
        wait_idle("len8192");
        chk_err("len8192", 0, 2'b00);
        check_all("len8192");

        r_hold = 1'b1;
        rl_base = rl_cnt;
        run_cmd(64'h0, 20480);
        repeat (60) @(negedge clk);
        chk64("hold_ar_count", 64'(obs_ar.size()), 64'd4);
        chk64("hold_arvalid", 64'(arvalid), 64'd0);
        chk64("hold_busy", 64'(busy), 64'd1);
        r_hold = 1'b0;
        wait_idle("hold");
        chk64("hold_4th_before_rlast", (obs_ar_rl.size() == 5) ? 64'(obs_ar_rl[3] - rl_base) : 64'hFF, 64'd0);
        chk64("hold_5th_after_rlast", (obs_ar_rl.size() == 5) ? 64'(obs_ar_rl[4] - rl_base >= 1) : 64'd0, 64'd1);
        chk_err("hold", 0, 2'b00);
        check_all("hold");

        send_cmd(64'h1004, 28'd256);
        repeat (8) @(negedge clk);
        chk_err("bad_align", 1, 2'b01);
        chk64("bad_align_ar", 64'(obs_ar.size()), 64'd0);
        chk64("bad_align_busy", 64'(busy), 64'd0);
        chk64("bad_align_ready", 64'(req_ready), 64'd1);

        send_cmd(64'h2000, 28'd0);
        repeat (8) @(negedge clk);
        chk_err("len0", 1, 2'b01);
        chk64("len0_ar", 64'(obs_ar.size()), 64'd0);
        chk64("len0_beats", 64'(obs_bt.size()), 64'd0);

        inj_addr = 64'h3040;
        run_cmd(64'h3000, 192);
        wait_idle("rresp");
        chk_err("rresp", 1, 2'b10);
        check_all("rresp");
        inj_addr = '1;

        for (int k = 0; k < 12; k++) begin
            va = 64'($urandom_range(0, 1023)) * 64'(NB);
            ln = (k % 4 == 0) ? int'($urandom_range(1, 64)) : int'($urandom_range(1, 3000));
            run_cmd(va, ln);
        end
        wait_idle("rand");
        chk_err("rand", 0, 2'b00);
        check_all("rand");

        chk64("max_outstanding", 64'(max_out), 64'd4);
        chk64("ar_stable_while_stalled", 64'(stable_viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
